axi_rw_arbiter: RTL and testbench
=================================

Name:
axi_rw_arbiter

Overview:
- Shares the core's single-outstanding AXI4 master port between two requesters: 0 = IFU instruction fetch, 1 = LSU data access.
- Runs round-robin arbitration, sequences the AR/R or AW/W/B handshakes for one beat, and returns data, completion and error to the granted requester.
- Sits between the pipeline's fetch/memory stages and the AXI interconnect.
- Burst length is fixed at 0, size at 8 bytes, and w_last is tied high downstream; none of these are ports here.

Parameters:
ADDR_W, 32, request/AXI address width
DATA_W, 64, data width; strobe width is DATA_W/8
ID_W, 4, AXI ID width; ar_id_o carries the requester index zero-extended

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low
req_i  in  2  per-requester request; held with payload until matching done_o bit
we_i  in  2  per-requester write enable (requester 0 never writes; we_i[0] ignored)
addr_i  in  2*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
wdata_i  in  2*DATA_W  packed write data
wstrb_i  in  2*DATA_W/8  packed byte strobes
rdata_o  out  DATA_W  read data, valid in the done_o cycle
done_o  out  2  one-cycle completion pulse to the granted requester
err_o  out  1  response was non-OKAY; valid with done_o
axi_ar_id_o  out  ID_W  read ID = granted index
axi_ar_addr_o  out  ADDR_W  read address
axi_ar_valid_o  out  1  AR valid
axi_ar_ready_i  in  1  AR ready
axi_r_data_i  in  DATA_W  read data
axi_r_resp_i  in  2  read response
axi_r_valid_i  in  1  R valid
axi_r_ready_o  out  1  R ready
axi_aw_addr_o  out  ADDR_W  write address
axi_aw_valid_o  out  1  AW valid
axi_aw_ready_i  in  1  AW ready
axi_w_data_o  out  DATA_W  write data
axi_w_strb_o  out  DATA_W/8  write strobes
axi_w_valid_o  out  1  W valid
axi_w_ready_i  in  1  W ready
axi_b_resp_i  in  2  write response
axi_b_valid_i  in  1  B valid
axi_b_ready_o  out  1  B ready

Behaviour:
- Reset (rst=0 at posedge): state IDLE, last_grant=0; all outputs 0.
  - Any in-flight AXI transaction is abandoned.
  - No done_o is issued for it.
- States: IDLE, RADDR, RDATA, WADDR, WRESP. All outputs are registered.
- IDLE, requester eligibility: req_i[i]=1 and done_o[i]=0 this cycle (masks the requester just completed).
- IDLE, arbitration:
  - One eligible requester: grant it.
  - Two eligible: grant ~last_grant.
  - On grant: latch index, we, addr, wdata, wstrb; last_grant <= index.
- IDLE, next state: we=1 -> WADDR with aw_valid=1, w_valid=1. Otherwise -> RADDR with ar_valid=1, ar_id=index.
- RADDR: hold ar_valid/addr/id stable until ar_ready=1. Then ar_valid<=0, r_ready<=1, -> RDATA.
- RDATA: on r_valid=1:
  - rdata_o<=r_data, err_o<=(r_resp!=0), done_o[index]<=1, r_ready<=0.
  - -> IDLE.
  - r_valid seen outside RDATA is ignored.
- WADDR:
  - aw_valid and w_valid each drop independently after their own handshake. Handshakes may occur in the same or different cycles.
  - When both have completed: b_ready<=1, -> WRESP.
- WRESP: on b_valid=1: err_o<=(b_resp!=0), done_o[index]<=1, b_ready<=0, -> IDLE. rdata_o is unchanged.
- done_o and err_o are single-cycle pulses; both clear the following cycle.
- Minimum latency with always-ready slave:
  - Read: req sampled at cycle 0, ar_valid at cycle 1, r_ready at cycle 2, done at cycle 3.
  - Write: done at cycle 3 after b_valid at cycle 2.
- Only one AXI transaction is outstanding at a time. No ID reordering.

Test Plan:
- IF read alone: req_i=01, addr0=0x8000_0000, ar_ready=1, r_valid=1 with data 0x0000_0297_0000_0013, resp 0 -> ar_addr=0x80000000, ar_id=0; done_o=01 at cycle 3; rdata matches; err 0.
- Simultaneous req_i=11 after reset, both reads -> MEM (1) granted first, IF second; last_grant alternates on repeated contention.
- MEM write, w_ready=1 immediately, aw_ready delayed 3 cycles -> w_valid high 1 cycle, aw_valid high 4 cycles; b_ready only after both; done_o=10 the cycle after b_valid.
- r_resp=2'b10 on MEM read -> done_o=10 with err_o=1; err_o=0 next cycle.
- Requester holds req through done cycle, drops it the next cycle -> exactly one AR handshake, no duplicate grant.
- rst=0 during WRESP -> next edge all outputs 0, state IDLE, no done_o; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/axi_rw_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI4 master port
// between instruction fetch (0) and load/store (1).
module axi_rw_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    input  logic [2*DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [1:0]            done_o,
    output logic                  err_o,
    output logic [ID_W-1:0]       axi_ar_id_o,
    output logic [ADDR_W-1:0]     axi_ar_addr_o,
    output logic                  axi_ar_valid_o,
    input  logic                  axi_ar_ready_i,
    input  logic [DATA_W-1:0]     axi_r_data_i,
    input  logic [1:0]            axi_r_resp_i,
    input  logic                  axi_r_valid_i,
    output logic                  axi_r_ready_o,
    output logic [ADDR_W-1:0]     axi_aw_addr_o,
    output logic                  axi_aw_valid_o,
    input  logic                  axi_aw_ready_i,
    output logic [DATA_W-1:0]     axi_w_data_o,
    output logic [DATA_W/8-1:0]   axi_w_strb_o,
    output logic                  axi_w_valid_o,
    input  logic                  axi_w_ready_i,
    input  logic [1:0]            axi_b_resp_i,
    input  logic                  axi_b_valid_i,
    output logic                  axi_b_ready_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          done_q, done_d;
    logic                err_q, err_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                b_ready_q, b_ready_d;

    logic [1:0] elig;
    logic       gnt;
    logic       gnt_we;
    logic       aw_left;
    logic       w_left;
    logic [1:0] done_vec;

    // A requester that completes this cycle is masked so it is not re-granted.
    assign elig     = req_i & ~done_q;
    assign gnt      = (elig == 2'b11) ? ~last_grant_q : elig[1];
    assign gnt_we   = gnt & we_i[1];
    assign aw_left  = aw_valid_q & ~axi_aw_ready_i;
    assign w_left   = w_valid_q & ~axi_w_ready_i;
    assign done_vec = idx_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        done_d       = 2'b00;
        err_d        = 1'b0;
        ar_valid_d   = ar_valid_q;
        r_ready_d    = r_ready_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        b_ready_d    = b_ready_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    idx_d        = gnt;
                    last_grant_d = gnt;
                    addr_d  = gnt ? addr_i[ADDR_W +: ADDR_W]
                                  : addr_i[0 +: ADDR_W];
                    wdata_d = gnt ? wdata_i[DATA_W +: DATA_W]
                                  : wdata_i[0 +: DATA_W];
                    wstrb_d = gnt ? wstrb_i[STRB_W +: STRB_W]
                                  : wstrb_i[0 +: STRB_W];
                    if (gnt_we) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WADDR;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RADDR;
                    end
                end
            end
            RADDR: begin
                if (axi_ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RDATA;
                end
            end
            RDATA: begin
                if (axi_r_valid_i) begin
                    rdata_d   = axi_r_data_i;
                    err_d     = |axi_r_resp_i;
                    done_d    = done_vec;
                    r_ready_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WADDR: begin
                aw_valid_d = aw_left;
                w_valid_d  = w_left;
                if (!aw_left && !w_left) begin
                    b_ready_d = 1'b1;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (axi_b_valid_i) begin
                    err_d     = |axi_b_resp_i;
                    done_d    = done_vec;
                    b_ready_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            idx_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            done_q       <= 2'b00;
            err_q        <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ar_valid_q   <= ar_valid_d;
            r_ready_q    <= r_ready_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
        end
    end

    assign rdata_o        = rdata_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign axi_ar_id_o    = {{(ID_W-1){1'b0}}, idx_q};
    assign axi_ar_addr_o  = addr_q;
    assign axi_ar_valid_o = ar_valid_q;
    assign axi_r_ready_o  = r_ready_q;
    assign axi_aw_addr_o  = addr_q;
    assign axi_aw_valid_o = aw_valid_q;
    assign axi_w_data_o   = wdata_q;
    assign axi_w_strb_o   = wstrb_q;
    assign axi_w_valid_o  = w_valid_q;
    assign axi_b_ready_o  = b_ready_q;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed bench for axi_rw_arbiter: reads, contention, split write
// handshakes, error responses and reset mid-transaction.
module tb_axi_rw_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_i;
    logic [1:0]    we_i;
    logic [63:0]   addr_i;
    logic [127:0]  wdata_i;
    logic [15:0]   wstrb_i;
    logic [63:0]   rdata_o;
    logic [1:0]    done_o;
    logic          err_o;
    logic [3:0]    ar_id;
    logic [31:0]   ar_addr;
    logic          ar_valid;
    logic          ar_ready;
    logic [63:0]   r_data;
    logic [1:0]    r_resp;
    logic          r_valid;
    logic          r_ready;
    logic [31:0]   aw_addr;
    logic          aw_valid;
    logic          aw_ready;
    logic [63:0]   w_data;
    logic [7:0]    w_strb;
    logic          w_valid;
    logic          w_ready;
    logic [1:0]    b_resp;
    logic          b_valid;
    logic          b_ready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_rw_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .we_i           (we_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .wstrb_i        (wstrb_i),
        .rdata_o        (rdata_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .axi_ar_id_o    (ar_id),
        .axi_ar_addr_o  (ar_addr),
        .axi_ar_valid_o (ar_valid),
        .axi_ar_ready_i (ar_ready),
        .axi_r_data_i   (r_data),
        .axi_r_resp_i   (r_resp),
        .axi_r_valid_i  (r_valid),
        .axi_r_ready_o  (r_ready),
        .axi_aw_addr_o  (aw_addr),
        .axi_aw_valid_o (aw_valid),
        .axi_aw_ready_i (aw_ready),
        .axi_w_data_o   (w_data),
        .axi_w_strb_o   (w_strb),
        .axi_w_valid_o  (w_valid),
        .axi_w_ready_i  (w_ready),
        .axi_b_resp_i   (b_resp),
        .axi_b_valid_i  (b_valid),
        .axi_b_ready_o  (b_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Always-ready slave read: AR at +1, R accepted at +2, done at +3.
    task automatic rd_seq(input string t, input logic idx,
                          input logic [31:0] a, input logic [63:0] d,
                          input logic [1:0] resp);
        r_data = d;
        r_resp = resp;
        step();
        chk({t, "_arv"}, ar_valid, 1);
        chk({t, "_arid"}, ar_id, {3'b0, idx});
        chk({t, "_araddr"}, ar_addr, a);
        chk({t, "_rrdy0"}, r_ready, 0);
        step();
        chk({t, "_rrdy"}, r_ready, 1);
        chk({t, "_arv0"}, ar_valid, 0);
        chk({t, "_nodone"}, done_o, 0);
        step();
        chk({t, "_done"}, done_o, idx ? 2'b10 : 2'b01);
        chk({t, "_rdata"}, rdata_o, d);
        chk({t, "_err"}, err_o, resp != 2'b00);
        chk({t, "_rrdy_clr"}, r_ready, 0);
    endtask

    initial begin
        rst = 1'b0;
        req_i = 2'b00; we_i = 2'b00;
        addr_i = '0; wdata_i = '0; wstrb_i = '0;
        ar_ready = 1'b0; r_data = '0; r_resp = 2'b00; r_valid = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_resp = 2'b00; b_valid = 1'b0;
        step();
        step();
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_arv", ar_valid, 0);
        chk("rst_awv", aw_valid, 0);
        chk("rst_wv", w_valid, 0);
        chk("rst_rrdy", r_ready, 0);
        chk("rst_brdy", b_ready, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_araddr", ar_addr, 0);
        rst = 1'b1;

        // IF read; we_i[0] must be ignored
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        req_i = 2'b01; we_i = 2'b01;
        addr_i[31:0]  = 32'h8000_0000;
        addr_i[63:32] = 32'h0000_1000;
        rd_seq("if_rd", 1'b0, 32'h8000_0000, 64'h0000_0297_0000_0013, 2'b00);
        chk("if_rd_noaw", aw_valid, 0);
        step();
        chk("nodup_arv", ar_valid, 0);
        chk("nodup_done", done_o, 0);
        req_i = 2'b00; we_i = 2'b00;
        step();
        chk("nodup_arv2", ar_valid, 0);

        // contention: MEM first, then IF
        req_i = 2'b11;
        rd_seq("c1", 1'b1, 32'h0000_1000, 64'h1111_2222_3333_4444, 2'b00);
        req_i = 2'b01;
        rd_seq("c2", 1'b0, 32'h8000_0000, 64'h5555_6666_7777_8888, 2'b00);
        req_i = 2'b00;
        step();
        req_i = 2'b11;
        rd_seq("c3", 1'b1, 32'h0000_1000, 64'h0123_4567_89ab_cdef, 2'b00);
        req_i = 2'b00;
        step();
        req_i = 2'b11;
        rd_seq("c4", 1'b0, 32'h8000_0000, 64'hfedc_ba98_7654_3210, 2'b00);
        req_i = 2'b00;
        step();

        // MEM read with SLVERR
        req_i = 2'b10;
        rd_seq("mem_err", 1'b1, 32'h0000_1000, 64'hdead_beef_0bad_f00d, 2'b10);
        req_i = 2'b00;
        step();
        chk("err_clr", err_o, 0);
        chk("err_done_clr", done_o, 0);
        r_resp = 2'b00;

        // MEM write, W ready at once, AW delayed
        req_i = 2'b10; we_i = 2'b10;
        addr_i[63:32] = 32'h0000_2000;
        wdata_i[127:64] = 64'hcafe_f00d_1234_5678;
        wstrb_i[15:8] = 8'hf0;
        aw_ready = 1'b0; w_ready = 1'b1;
        step();
        chk("wr_awv1", aw_valid, 1);
        chk("wr_wv1", w_valid, 1);
        chk("wr_awaddr", aw_addr, 32'h0000_2000);
        chk("wr_wdata", w_data, 64'hcafe_f00d_1234_5678);
        chk("wr_wstrb", w_strb, 8'hf0);
        chk("wr_noar", ar_valid, 0);
        step();
        chk("wr_awv2", aw_valid, 1);
        chk("wr_wv2", w_valid, 0);
        chk("wr_brdy2", b_ready, 0);
        step();
        chk("wr_awv3", aw_valid, 1);
        step();
        chk("wr_awv4", aw_valid, 1);
        chk("wr_brdy4", b_ready, 0);
        aw_ready = 1'b1;
        step();
        chk("wr_awv5", aw_valid, 0);
        chk("wr_brdy5", b_ready, 1);
        chk("wr_nodone", done_o, 0);
        b_valid = 1'b1; b_resp = 2'b00;
        step();
        chk("wr_done", done_o, 2'b10);
        chk("wr_err", err_o, 0);
        chk("wr_brdy_clr", b_ready, 0);
        chk("wr_rdata_keep", rdata_o, 64'hdead_beef_0bad_f00d);
        req_i = 2'b00; we_i = 2'b00;
        b_valid = 1'b0; aw_ready = 1'b0;
        step();
        chk("wr_done_clr", done_o, 0);

        // reset while waiting in WRESP
        aw_ready = 1'b1; w_ready = 1'b1;
        req_i = 2'b10; we_i = 2'b10;
        step();
        chk("rw_awv", aw_valid, 1);
        step();
        chk("rw_brdy", b_ready, 1);
        rst = 1'b0; b_valid = 1'b1;
        req_i = 2'b00; we_i = 2'b00;
        step();
        chk("rw_brdy0", b_ready, 0);
        chk("rw_done0", done_o, 0);
        chk("rw_awv0", aw_valid, 0);
        chk("rw_wv0", w_valid, 0);
        chk("rw_arv0", ar_valid, 0);
        chk("rw_rdata0", rdata_o, 0);
        chk("rw_awaddr0", aw_addr, 0);
        rst = 1'b1; b_valid = 1'b0;
        step();
        chk("rw_idle_done", done_o, 0);
        req_i = 2'b10;
        rd_seq("post_rst", 1'b1, 32'h0000_2000, 64'h0f0f_0f0f_a5a5_a5a5, 2'b00);
        req_i = 2'b00;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
